// File: rtl/mmio_uart_pkg.sv
// Shared constants for the MMIO UART controller: register word offsets,
// CTRL status bit positions and the default I/O-space address nibble.
package mmio_uart_pkg;

  localparam logic [3:0] IO_BASE_NIBBLE_DEF = 4'h8;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_RXDATA = 3'd1;
  localparam logic [2:0] OFF_TXDATA = 3'd2;
  localparam logic [2:0] OFF_CYCLE  = 3'd4;
  localparam logic [2:0] OFF_INSTR  = 3'd5;
  localparam logic [2:0] OFF_CNTCLR = 3'd6;

  localparam int CTRL_TX_FREE_BIT = 0;
  localparam int CTRL_RX_AVAIL_BIT = 1;

endpackage

// File: rtl/mmio_uart_ctrl_rx_fifo.sv
// Byte FIFO for received UART data; pointers carry one extra wrap bit
// so that full and empty are distinguishable with equal low bits.
module io_rx_fifo #(
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int unsigned AW = $clog2(RX_DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [RX_DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)  wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop  && !empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// I/O-space register block next to data memory: UART RX FIFO, TX holding
// register, cycle/instret counters, and a registered read port for writeback.
module mmio_uart_ctrl
  import mmio_uart_pkg::*;
#(
  parameter logic [3:0]  IO_BASE_NIBBLE = IO_BASE_NIBBLE_DEF,
  parameter int unsigned RX_DEPTH       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_we,
  input  logic        io_re,
  input  logic        instr_retire,
  output logic [31:0] io_rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  logic        hit;
  logic [2:0]  off;
  logic        rd_req, wr_ok;
  logic        rx_pop, rx_push, rx_empty, rx_full;
  logic [7:0]  rx_dout;
  logic        tx_load, cnt_clr;
  logic [31:0] rd_mux;

  logic [31:0] rdata_q, rdata_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instr_q, instr_d;

  logic unused_bits;
  assign unused_bits = ^{io_addr[27:5], io_addr[1:0], io_wdata[31:8]};

  assign hit     = (io_addr[31:28] == IO_BASE_NIBBLE);
  assign off     = io_addr[4:2];
  assign rd_req  = io_re && !stall;
  assign wr_ok   = hit && !stall;
  assign rx_pop  = rd_req && hit && (off == OFF_RXDATA) && !rx_empty;
  assign rx_push = uart_rx_valid && !rx_full;
  // Busy TX (including the handshake cycle itself) drops the store.
  assign tx_load = wr_ok && (off == OFF_TXDATA) && io_we[0] && !tx_valid_q;
  assign cnt_clr = wr_ok && (off == OFF_CNTCLR) && (|io_we);

  io_rx_fifo #(.RX_DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (uart_rx_data),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full)
  );

  always_comb begin
    rd_mux = '0;
    if (hit) begin
      case (off)
        OFF_CTRL: begin
          rd_mux[CTRL_TX_FREE_BIT]  = !tx_valid_q;
          rd_mux[CTRL_RX_AVAIL_BIT] = !rx_empty;
        end
        OFF_RXDATA: if (!rx_empty) rd_mux = {24'd0, rx_dout};
        OFF_CYCLE:  rd_mux = cycle_q;
        OFF_INSTR:  rd_mux = instr_q;
        default:    rd_mux = '0;
      endcase
    end
  end

  always_comb begin
    rdata_d    = rdata_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (rd_req) rdata_d = rd_mux;
    if (tx_load) begin
      tx_valid_d = 1'b1;
      tx_data_d  = io_wdata[7:0];
    end else if (tx_valid_q && uart_tx_ready) begin
      tx_valid_d = 1'b0;
    end
    cycle_d = cnt_clr ? '0 : cycle_q + 32'd1;
    instr_d = cnt_clr ? '0 : instr_q + {31'd0, instr_retire && !stall};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      cycle_q    <= '0;
      instr_q    <= '0;
    end else begin
      rdata_q    <= rdata_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cycle_q    <= cycle_d;
      instr_q    <= instr_d;
    end
  end

  assign io_rdata      = rdata_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_tx_valid = tx_valid_q;
  assign uart_rx_ready = !rx_full;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Bench for mmio_uart_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mmio_uart_ctrl;
  localparam int RX_DEPTH = 8;
  localparam logic [31:0] A_CTRL   = 32'h8000_0000;
  localparam logic [31:0] A_RXDATA = 32'h8000_0004;
  localparam logic [31:0] A_TXDATA = 32'h8000_0008;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0010;
  localparam logic [31:0] A_INSTR  = 32'h8000_0014;
  localparam logic [31:0] A_CNTCLR = 32'h8000_0018;

  logic clk = 1'b0;
  logic rst, stall, io_re, instr_retire;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic [3:0]  io_we;
  logic [7:0]  uart_tx_data, uart_rx_data;
  logic uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_ready;

  always #5 clk = ~clk;

  mmio_uart_ctrl #(.IO_BASE_NIBBLE(4'h8), .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_we(io_we), .io_re(io_re), .instr_retire(instr_retire), .io_rdata(io_rdata),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  byte unsigned rx_m[$];
  logic        tx_valid_m;
  logic [7:0]  tx_data_m;
  logic [31:0] cycle_m, instr_m, rdata_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rx_m.delete();
    tx_valid_m = 1'b0;
    tx_data_m  = 8'd0;
    cycle_m    = 32'd0;
    instr_m    = 32'd0;
    rdata_m    = 32'd0;
  endtask

  // Next state from the register-map rules, using the inputs present now.
  task automatic model_step();
    bit hit, rx_room, pop, push, clr;
    int off;
    logic [31:0] rd;
    hit     = (io_addr[31:28] == 4'h8);
    off     = int'(io_addr[4:2]);
    rx_room = (rx_m.size() < RX_DEPTH);
    pop     = 0;
    if (io_re && !stall) begin
      rd = 32'd0;
      if (hit) begin
        if (off == 0) rd = {30'd0, rx_m.size() != 0, !tx_valid_m};
        else if (off == 1 && rx_m.size() != 0) rd = {24'd0, rx_m[0]};
        else if (off == 4) rd = cycle_m;
        else if (off == 5) rd = instr_m;
      end
      rdata_m = rd;
      pop = hit && off == 1 && rx_m.size() != 0;
    end
    push = uart_rx_valid && rx_room;
    if (pop) void'(rx_m.pop_front());
    if (push) rx_m.push_back(uart_rx_data);
    if (!stall && hit && off == 2 && io_we[0] && !tx_valid_m) begin
      tx_valid_m = 1'b1;
      tx_data_m  = io_wdata[7:0];
    end else if (tx_valid_m && uart_tx_ready) begin
      tx_valid_m = 1'b0;
    end
    clr = !stall && hit && off == 6 && (io_we != 4'd0);
    cycle_m = clr ? 32'd0 : cycle_m + 32'd1;
    instr_m = clr ? 32'd0 : instr_m + ((instr_retire && !stall) ? 32'd1 : 32'd0);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("io_rdata", io_rdata, rdata_m);
    chk("tx_valid", 32'(uart_tx_valid), 32'(tx_valid_m));
    chk("tx_data", 32'(uart_tx_data), 32'(tx_data_m));
    chk("rx_ready", 32'(uart_rx_ready), (rx_m.size() < RX_DEPTH) ? 32'd1 : 32'd0);
  endtask

  task automatic idle();
    stall = 0; io_re = 0; io_we = 4'd0; io_addr = 32'd0; io_wdata = 32'd0;
    instr_retire = 0; uart_tx_ready = 0; uart_rx_valid = 0; uart_rx_data = 8'd0;
  endtask

  task automatic rd(input logic [31:0] a);
    io_re = 1; io_addr = a;
    step();
    io_re = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d, input logic [3:0] we);
    io_addr = a; io_wdata = {24'hABCDEF, d}; io_we = we;
    step();
    io_we = 4'd0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", io_rdata, 32'd0);
    chk("reset_tx_valid", 32'(uart_tx_valid), 32'd0);
    chk("reset_tx_data", 32'(uart_tx_data), 32'd0);
    chk("reset_rx_ready", 32'(uart_rx_ready), 32'd1);
    rst = 1'b1;
    model_reset();

    rd(A_CTRL);
    chk("ctrl_after_reset", io_rdata, 32'h1);

    // RX: two bytes in, drained in order, then an empty read.
    uart_rx_valid = 1; uart_rx_data = 8'h41; step();
    uart_rx_data = 8'h42; step();
    uart_rx_valid = 0;
    rd(A_RXDATA); chk("rx_first", io_rdata, 32'h41);
    rd(A_RXDATA); chk("rx_second", io_rdata, 32'h42);
    rd(A_RXDATA); chk("rx_empty_read", io_rdata, 32'h0);
    rd(A_CTRL);   chk("ctrl_rx_drained", io_rdata, 32'h1);

    // RX full back-pressure.
    uart_rx_valid = 1;
    for (int i = 0; i < RX_DEPTH; i++) begin
      uart_rx_data = 8'(8'h10 + i);
      step();
    end
    chk("rx_full_ready", 32'(uart_rx_ready), 32'd0);
    uart_rx_data = 8'h99;
    step(); step();
    rd(A_RXDATA);
    chk("rx_full_pop", io_rdata, 32'h10);
    chk("rx_ready_after_pop", 32'(uart_rx_ready), 32'd1);
    step();
    uart_rx_valid = 0;
    for (int i = 1; i < RX_DEPTH; i++) begin
      rd(A_RXDATA);
      chk("rx_drain", io_rdata, 32'(8'h10 + i));
    end
    rd(A_RXDATA); chk("rx_held_byte", io_rdata, 32'h99);
    rd(A_RXDATA); chk("rx_drained_empty", io_rdata, 32'h0);

    // TX holding register.
    wr(A_TXDATA, 8'h55, 4'b0001);
    chk("tx_load_valid", 32'(uart_tx_valid), 32'd1);
    chk("tx_load_data", 32'(uart_tx_data), 32'h55);
    wr(A_TXDATA, 8'h66, 4'b0001);
    chk("tx_busy_drop", 32'(uart_tx_data), 32'h55);
    uart_tx_ready = 1; step(); uart_tx_ready = 0;
    chk("tx_done_valid", 32'(uart_tx_valid), 32'd0);
    chk("tx_done_data", 32'(uart_tx_data), 32'h55);
    wr(A_TXDATA, 8'h77, 4'b0001);
    uart_tx_ready = 1;
    wr(A_TXDATA, 8'h88, 4'b0001);
    uart_tx_ready = 0;
    chk("tx_hs_write_drop_valid", 32'(uart_tx_valid), 32'd0);
    chk("tx_hs_write_drop_data", 32'(uart_tx_data), 32'h77);
    wr(A_TXDATA, 8'h99, 4'b0010);
    chk("tx_we0_required", 32'(uart_tx_valid), 32'd0);
    wr(A_TXDATA, 8'h99, 4'b0001);
    chk("tx_reload", 32'(uart_tx_data), 32'h99);
    uart_tx_ready = 1; step(); uart_tx_ready = 0;

    // Counters: clear beats same-cycle retire.
    instr_retire = 1;
    wr(A_CNTCLR, 8'h00, 4'b1000);
    instr_retire = 0;
    step();
    rd(A_CYCLE); chk("cycle_after_clear", io_rdata, 32'd1);
    for (int i = 0; i < 100; i++) begin
      instr_retire = (i < 60);
      stall = (i >= 50 && i < 60);
      step();
    end
    instr_retire = 0; stall = 0;
    rd(A_INSTR); chk("instr_count", io_rdata, 32'd50);
    rd(A_CYCLE); chk("cycle_ge_100", (io_rdata >= 32'd100) ? 32'd1 : 32'd0, 32'd1);

    // Stalled read holds io_rdata.
    stall = 1; rd(A_CTRL); stall = 0;
    chk("stall_hold", io_rdata, rdata_m);

    // Counter wrap, exercised by forcing the counter to its maximum.
    force dut.cycle_q = 32'hFFFF_FFFF;
    io_re = 1; io_addr = A_CYCLE;
    #1;
    chk("cycle_wrap_next", dut.cycle_d, 32'd0);
    @(posedge clk);
    #1;
    chk("cycle_read_max", io_rdata, 32'hFFFF_FFFF);
    release dut.cycle_q;
    io_re = 0;
    rdata_m = 32'hFFFF_FFFF;
    wr(A_CNTCLR, 8'h00, 4'b0001);
    rd(A_CYCLE); chk("cycle_resync", io_rdata, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      io_re = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) io_addr = 32'h1000_0000 | 32'($urandom_range(0, 31));
      else io_addr = {4'h8, 23'($urandom), 3'($urandom_range(0, 7)), 2'($urandom)};
      io_we = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      io_wdata = $urandom;
      instr_retire = ($urandom_range(0, 1) == 1);
      uart_tx_ready = ($urandom_range(0, 2) == 0);
      uart_rx_valid = ($urandom_range(0, 1) == 1);
      uart_rx_data = 8'($urandom);
      step();
    end
    idle();

    // Asynchronous reset with a pending TX byte and buffered RX data.
    wr(A_TXDATA, 8'hA5, 4'b0001);
    uart_rx_valid = 1; uart_rx_data = 8'h3C; step(); step(); uart_rx_valid = 0;
    chk("pre_reset_tx_valid", 32'(uart_tx_valid), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("async_reset_tx_valid", 32'(uart_tx_valid), 32'd0);
    chk("async_reset_rdata", io_rdata, 32'd0);
    chk("async_reset_rx_ready", 32'(uart_rx_ready), 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd(A_CTRL); chk("ctrl_after_async_reset", io_rdata, 32'h1);
    rd(A_RXDATA); chk("rx_discarded", io_rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
